mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DataWidth, default 32, is the width of all data buses.
REQ-002 Parameter AddrWidth, default 32, is the width of all address buses.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: CLK  input  1  rising-edge clock; RST  input  1  asynchronous active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-005 if_addr  input  AddrWidth  fetch byte address, held stable while if_req is high.
REQ-006 if_ack  output  1  one-cycle pulse signalling that if_rdata is valid.
REQ-007 if_rdata  output  DataWidth  registered fetch data.
REQ-008 d_req  input  1  data access request, held until d_ack.
REQ-009 d_we  input  1  d_req write qualifier: 1 = store, 0 = load.
REQ-010 d_addr  input  AddrWidth  data byte address, held stable while d_req is high.
REQ-011 d_wdata  input  DataWidth  store data, held stable while d_req is high.
REQ-012 d_ack  output  1  one-cycle pulse signalling completion of the load or store.
REQ-013 d_rdata  output  DataWidth  registered load data.
REQ-014 mem_addr  output  AddrWidth  address driven to the shared unified RAM.
REQ-015 mem_r  output  1  RAM read enable.
REQ-016 mem_w  output  1  RAM write enable.
REQ-017 mem_wdata  output  DataWidth  RAM write data.
REQ-018 mem_rdata  input  DataWidth  combinational RAM read data; undefined while mem_r is 0.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, GRANT_I, GRANT_D and RESP.
REQ-020 In IDLE with only if_req high, the next state SHALL be GRANT_I; with only d_req high, GRANT_D; with neither high, IDLE.
REQ-021 In IDLE with if_req and d_req both high, the grant SHALL go to the requester opposite last_grant, then last_grant SHALL update to the winner (round-robin).
REQ-022 In GRANT_I, the outputs SHALL be mem_addr=if_addr, mem_r=1, mem_w=0.
REQ-023 In GRANT_D, the outputs SHALL be mem_addr=d_addr, mem_wdata=d_wdata, mem_r=!d_we, mem_w=d_we.
REQ-024 At the edge leaving GRANT_I, mem_rdata SHALL be captured into if_rdata; at the edge leaving GRANT_D with d_we=0, it SHALL be captured into d_rdata.
REQ-025 d_rdata SHALL remain unchanged on a store.
REQ-026 GRANT_x SHALL always advance to RESP after one cycle.
REQ-027 In RESP, exactly one of if_ack or d_ack SHALL be 1 (the served requester), and the next state SHALL be IDLE.
REQ-028 Access latency SHALL be 3 cycles (IDLE, GRANT, RESP) from req sampled high to ack high, and throughput SHALL be one access per 3 cycles.
REQ-029 Requesters deassert req at the edge where ack is sampled; a req still high in IDLE after RESP SHALL be treated as a new request.
REQ-030 mem_r, mem_w, if_ack and d_ack SHALL be 0 in every state not listed above; mem_addr and mem_wdata SHALL be 0 in IDLE and RESP.
REQ-031 if_rdata and d_rdata SHALL hold their value until the next capture for the same port.
REQ-032 Addresses SHALL pass through unmodified; the block performs no alignment or range checking.
REQ-033 A req falling during GRANT (protocol violation) SHALL NOT abort the access; the FSM completes and pulses ack.

Reset
REQ-034 While RST=1, the outputs SHALL be state=IDLE, last_grant=D (so IF wins the first conflict), if_rdata=0, d_rdata=0, and all acks, mem_r, mem_w and mem_* buses=0.
REQ-035 RST asserted mid-GRANT_D with d_we=1 SHALL drop mem_w immediately (asynchronously), and no ack SHALL be issued for the aborted access.

Structure
REQ-036 The state encoding (2-bit) and the grant-owner encoding (I=0, D=1) SHALL be placed in a shared package/include used by the controller and testbench.
REQ-037 The block SHALL be one flat module with no sub-module; the RAM SHALL be instantiated beside it at the top level.

Verification
REQ-038 Reset, then if_req=1 with if_addr=0x0: the bench SHALL see mem_r=1 in cycle 2 and if_ack=1 in cycle 3 with if_rdata=0x00421821 (RAM preloaded).
REQ-039 Store with d_we=1, d_addr=0x3C, d_wdata=0xDEADBEEF, then a load from 0x3C: the bench SHALL see mem_w high for exactly 1 cycle and d_rdata=0xDEADBEEF on the second d_ack.
REQ-040 if_req and d_req raised in the same cycle after reset: the bench SHALL see if_ack served first, then d_ack 3 cycles later, and the next conflict served D first.
REQ-041 if_req held continuously for 4 accesses: the bench SHALL see if_ack pulses at cycles 3, 6, 9 and 12 relative to the first request, with no back-to-back acks.
REQ-042 RST pulsed during GRANT_D of a store to 0x40 holding 0x0: the bench SHALL see mem[0x40] remain 0x0 (write may land only if an edge-free window was missed, so the check samples mem_w=0 within the reset cycle), no d_ack, and the FSM in IDLE.
REQ-043 No request for 10 cycles: the bench SHALL see mem_r=mem_w=0 and both acks 0 throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter and anything
//   that observes it.
//   - state_e : 2-bit controller state encoding.
//   - owner_e : grant owner encoding (I = 0, D = 1).
//   - pick_owner : round-robin winner selection for the IDLE state.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } owner_e;

  // With both requesters pending, the one that did not win the previous
  // conflict is served; otherwise whichever requester is present wins.
  // The result is only meaningful when at least one request is high.
  function automatic owner_e pick_owner(input logic   if_req,
                                        input logic   d_req,
                                        input owner_e last);
    if (if_req && d_req) begin
      return (last == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req) begin
      return GNT_D;
    end else begin
      return GNT_I;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data load/store port onto one
//   shared unified RAM with combinational read data. One access is served
//   every three cycles: IDLE (request sampled), GRANT_x (RAM driven),
//   RESP (ack pulse).
//
// Handshake: a requester raises its req and holds it (with address and
//   write data stable) until it samples its ack high; ack is a one-cycle
//   pulse and the requester drops req at that same edge. A req still high
//   when the controller is back in IDLE counts as a new request. Once
//   granted, an access always completes even if req falls early.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   if_req/if_addr        fetch request and byte address
//   if_ack/if_rdata       fetch completion pulse and registered read data
//   d_req/d_we/d_addr/d_wdata  data request, store qualifier, address, data
//   d_ack/d_rdata         data completion pulse and registered load data
//   mem_addr/mem_r/mem_w/mem_wdata/mem_rdata  shared RAM interface
//   state, last_grant     debug view of the controller state and the
//                         winner of the most recent conflict
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_ack,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [AddrWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_ack,
  output logic [DataWidth-1:0] d_rdata,
  output logic [AddrWidth-1:0] mem_addr,
  output logic                 mem_r,
  output logic                 mem_w,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  output state_e               state,
  output owner_e               last_grant
);

  owner_e winner_d;
  logic   conflict_d;

  assign winner_d   = pick_owner(if_req, d_req, last_grant);
  assign conflict_d = if_req && d_req;

  // All outputs are registered. RAM controls are loaded on the IDLE->GRANT
  // edge from the (stable) request inputs, so a request that falls during
  // GRANT cannot disturb the access in flight. Reset clears them
  // asynchronously, which also cancels an in-flight store immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      last_grant <= GNT_D;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_addr   <= '0;
      mem_r      <= 1'b0;
      mem_w      <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_req || d_req) begin
            // last_grant only tracks conflicts; an uncontested grant does
            // not change who wins the next tie.
            if (conflict_d) begin
              last_grant <= winner_d;
            end
            if (winner_d == GNT_I) begin
              state     <= ST_GRANT_I;
              mem_addr  <= if_addr;
              mem_r     <= 1'b1;
              mem_w     <= 1'b0;
              mem_wdata <= '0;
            end else begin
              state     <= ST_GRANT_D;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_r     <= !d_we;
              mem_w     <= d_we;
            end
          end
        end

        ST_GRANT_I: begin
          if_rdata  <= mem_rdata;
          if_ack    <= 1'b1;
          mem_addr  <= '0;
          mem_r     <= 1'b0;
          mem_w     <= 1'b0;
          mem_wdata <= '0;
          state     <= ST_RESP;
        end

        ST_GRANT_D: begin
          // mem_r is high exactly for a load; stores leave d_rdata alone.
          if (mem_r) begin
            d_rdata <= mem_rdata;
          end
          d_ack     <= 1'b1;
          mem_addr  <= '0;
          mem_r     <= 1'b0;
          mem_w     <= 1'b0;
          mem_wdata <= '0;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with a 64-word unified RAM model beside the DUT.
//   Directed stimulus pushes the expected {owner, data} of each access into
//   exp_q; a negedge monitor pops and compares on every ack.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int W  = DW + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_r;
  logic          mem_w;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  state_e        state;
  owner_e        last_grant;

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_r      (mem_r),
    .mem_w      (mem_w),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .state      (state),
    .last_grant (last_grant)
  );

  // ---------------- RAM model ----------------
  // Word-addressed by byte address [7:2]. Read data is a poison pattern
  // while mem_r is low so a stray capture is visible.
  logic [DW-1:0] ram [0:63] = '{0: 32'h00421821, 1: 32'h8C220004,
                                2: 32'h12345678, 3: 32'hCAFEF00D,
                                default: 32'h0};

  assign mem_rdata = (mem_r && mem_addr < 256) ? ram[mem_addr[7:2]] : 32'hBAD0BAD0;

  always @(posedge CLK) begin
    if (mem_w && mem_addr < 256) ram[mem_addr[7:2]] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic         prev_ack = 1'b0;
  logic [W-1:0] e;
  always @(negedge CLK) begin
    if (!RST && (if_ack || d_ack)) begin
      check("ack_onehot", 64'(if_ack & d_ack), 64'd0);
      check("ack_spacing", 64'(prev_ack), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b, expected none (cycle %0d)",
                 if_ack, d_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 64'(d_ack), 64'(e[W-1]));
        check("ack_data", 64'(d_ack ? d_rdata : if_rdata), 64'(e[DW-1:0]));
      end
    end
    prev_ack = if_ack | d_ack;
  end

  // mem_w activity, sampled mid-cycle
  int            mw_cnt = 0;
  logic [AW-1:0] mw_addr = '0;
  logic [DW-1:0] mw_data = '0;
  always @(negedge CLK) begin
    if (mem_w) begin
      mw_cnt++;
      mw_addr = mem_addr;
      mw_data = mem_wdata;
    end
  end

  // ---------------- driver helpers ----------------
  // Waits (bounded) for the ack of one port; rel is the cycle number of the
  // ack counting the cycle in which the request was first sampled as 1.
  task automatic wait_ack(input logic port, input int start, input logic drop, output int rel);
    rel = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (port ? d_ack : if_ack) begin
        rel = cyc - start + 1;
        if (drop) begin
          if (port) d_req = 1'b0;
          else      if_req = 1'b0;
        end
        break;
      end
    end
    if (rel < 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL ack_timeout: port %0d got no ack, expected one within 20 cycles", port);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int s;
  int rel;
  int w0;

  initial begin
    repeat (2) @(negedge CLK);
    // reset state
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_last_grant", 64'(last_grant), 64'(GNT_D));
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_acks", 64'({if_ack, d_ack}), 64'd0);
    check("rst_mem_ctl", 64'({mem_r, mem_w}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    RST = 1'b0;

    // idle: nothing moves for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_quiet", 64'({mem_r, mem_w, if_ack, d_ack}), 64'd0);
    end

    // first fetch from address 0
    if_addr = 32'h0;
    if_req  = 1'b1;
    exp_q.push_back({GNT_I, 32'h00421821});
    s = cyc;
    @(negedge CLK);
    check("fetch_grant_state", 64'(state), 64'(ST_GRANT_I));
    check("fetch_grant_mem_r", 64'(mem_r), 64'd1);
    check("fetch_grant_mem_w", 64'(mem_w), 64'd0);
    check("fetch_grant_addr", 64'(mem_addr), 64'h0);
    wait_ack(1'b0, s, 1'b1, rel);
    check("fetch_latency", 64'(rel), 64'd3);

    // store 0xDEADBEEF to 0x3C; d_rdata must stay 0
    @(negedge CLK);
    w0 = mw_cnt;
    d_we = 1'b1; d_addr = 32'h3C; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    exp_q.push_back({GNT_D, 32'h0});
    s = cyc;
    wait_ack(1'b1, s, 1'b1, rel);
    check("store_latency", 64'(rel), 64'd3);
    check("store_mem_w_cycles", 64'(mw_cnt - w0), 64'd1);
    check("store_mem_addr", 64'(mw_addr), 64'h3C);
    check("store_mem_wdata", 64'(mw_data), 64'hDEADBEEF);

    // load back from 0x3C
    @(negedge CLK);
    d_we = 1'b0; d_req = 1'b1;
    exp_q.push_back({GNT_D, 32'hDEADBEEF});
    s = cyc;
    @(negedge CLK);
    check("load_grant_ctl", 64'({mem_r, mem_w}), 64'b10);
    wait_ack(1'b1, s, 1'b1, rel);
    check("load_latency", 64'(rel), 64'd3);

    // first conflict: IF wins (last_grant was D from reset)
    @(negedge CLK);
    if_addr = 32'h4; d_addr = 32'h3C; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    exp_q.push_back({GNT_I, 32'h8C220004});
    exp_q.push_back({GNT_D, 32'hDEADBEEF});
    s = cyc;
    wait_ack(1'b0, s, 1'b1, rel);
    check("conflict1_if_cycle", 64'(rel), 64'd3);
    wait_ack(1'b1, s, 1'b1, rel);
    check("conflict1_d_cycle", 64'(rel), 64'd6);
    check("conflict1_last_grant", 64'(last_grant), 64'(GNT_I));

    // second conflict: D wins
    @(negedge CLK);
    if_addr = 32'h8; d_addr = 32'h0;
    if_req = 1'b1; d_req = 1'b1;
    exp_q.push_back({GNT_D, 32'h00421821});
    exp_q.push_back({GNT_I, 32'h12345678});
    s = cyc;
    wait_ack(1'b1, s, 1'b1, rel);
    check("conflict2_d_cycle", 64'(rel), 64'd3);
    wait_ack(1'b0, s, 1'b1, rel);
    check("conflict2_if_cycle", 64'(rel), 64'd6);
    check("conflict2_last_grant", 64'(last_grant), 64'(GNT_D));

    // if_req held for four back-to-back fetches
    @(negedge CLK);
    if_addr = 32'hC; if_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({GNT_I, 32'hCAFEF00D});
    s = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, s, (i == 3), rel);
      check("held_ack_cycle", 64'(rel), 64'(3 * (i + 1)));
    end

    // d_req dropped during GRANT: access still completes
    @(negedge CLK);
    d_addr = 32'h0; d_we = 1'b0; d_req = 1'b1;
    exp_q.push_back({GNT_D, 32'h00421821});
    s = cyc;
    @(negedge CLK);
    d_req = 1'b0;
    wait_ack(1'b1, s, 1'b1, rel);
    check("early_drop_latency", 64'(rel), 64'd3);

    // reset in the middle of a store to 0x40
    @(negedge CLK);
    d_addr = 32'h40; d_wdata = 32'h55AA55AA; d_we = 1'b1; d_req = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_grant_mem_w", 64'(mem_w), 64'd1);
    RST = 1'b1;
    #1;
    check("abort_mem_w_async", 64'(mem_w), 64'd0);
    check("abort_no_ack", 64'(d_ack), 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_state", 64'(state), 64'(ST_IDLE));
    check("abort_mem_w_held", 64'(mem_w), 64'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("abort_no_d_ack", 64'(d_ack), 64'd0);
    end
    check("abort_ram_0x40", 64'(ram[16]), 64'h0);
    check("abort_state_after", 64'(state), 64'(ST_IDLE));

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
